// File: rtl/frame_stream_gen_if.sv
// Pixel stream bus: valid/ready handshake with frame and line markers.
interface frame_stream_gen_if #(
  parameter int unsigned DATA_W = 24
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_sof;
  logic              m_eol;
  logic              m_eof;

  modport master (
    output m_valid,
    output m_data,
    output m_sof,
    output m_eol,
    output m_eof,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_sof,
    input  m_eol,
    input  m_eof,
    output m_ready
  );
endinterface

// File: rtl/frame_stream_gen.sv
// Camera-style stream source: replays a stored image from a 1-cycle sync RAM as a pixel stream
// with sof/eol/eof markers, horizontal blanking, valid/ready backpressure and frame counting.
module frame_stream_gen #(
  parameter int unsigned IMG_W      = 320,
  parameter int unsigned IMG_H      = 240,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned NUM_FRAMES = 2,
  parameter int unsigned BLANK_CYC  = 4,
  localparam int unsigned ADDR_W    = $clog2(IMG_W * IMG_H),
  localparam int unsigned DATA_W    = PIX_W * CHANNELS
) (
  input  logic              CAMERA_CLK,
  input  logic              rst,
  input  logic              start,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  frame_stream_gen_if.master m_if,
  output logic              frame_done,
  output logic              all_done,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [XW-1:0]     XLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     YLast = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ALast = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [BW-1:0]     BLast = BW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

  typedef enum logic [2:0] {StIdle, StActive, StHblank, StDrain, StDone} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eol;
    logic              eof;
  } pix_t;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0]     blank_q, blank_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              all_done_q, all_done_d;
  logic              busy_q, busy_d;
  // Read in flight: markers ride alongside until the RAM word returns.
  logic              rd_q, rd_d;
  logic [2:0]        rd_mk_q, rd_mk_d;
  pix_t              buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]        cnt_q, cnt_d;

  pix_t       in_pix, head, second;
  logic [1:0] total;
  logic       valid, pop, issue;

  // Skid buffer view: the returning RAM word counts as the tail entry.
  always_comb begin
    in_pix.data = mem_rdata;
    in_pix.sof  = rd_mk_q[2];
    in_pix.eol  = rd_mk_q[1];
    in_pix.eof  = rd_mk_q[0];
    total       = cnt_q + {1'b0, rd_q};
    head        = (cnt_q != 2'd0) ? buf0_q : in_pix;
    second      = (cnt_q == 2'd2) ? buf1_q : in_pix;
    valid       = (total != 2'd0);
    pop         = valid & m_if.m_ready;
    issue       = (state_q == StActive) && (total < 2'd2);
    if (pop) begin
      buf0_d = second;
      buf1_d = buf1_q;
      cnt_d  = total - 2'd1;
    end else begin
      buf0_d = head;
      buf1_d = second;
      cnt_d  = total;
    end
    rd_d    = issue;
    rd_mk_d = {(x_q == '0) && (y_q == '0), x_q == XLast, (x_q == XLast) && (y_q == YLast)};
  end

  // Control FSM: read issue, blanking, frame accounting.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    blank_d      = blank_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    all_done_d   = all_done_q;
    busy_d       = busy_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StActive;
          x_d         = '0;
          y_d         = '0;
          addr_d      = '0;
          blank_d     = '0;
          frame_cnt_d = '0;
          busy_d      = 1'b1;
          all_done_d  = 1'b0;
        end
      end
      StActive: begin
        if (issue) begin
          addr_d = (addr_q == ALast) ? '0 : addr_q + 1'b1;
          if (x_q == XLast) begin
            x_d = '0;
            if (y_q == YLast) begin
              state_d = StDrain;
            end else if (BLANK_CYC > 0) begin
              state_d = StHblank;
              blank_d = '0;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      StHblank: begin
        // Blanking holds while the buffer is full.
        if (cnt_q != 2'd2) begin
          if (blank_q == BLast) begin
            state_d = StActive;
            blank_d = '0;
            y_d     = y_q + 1'b1;
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (pop && head.eof) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
          if ((NUM_FRAMES == 0) || (({1'b0, frame_cnt_q} + 17'd1) < 17'(NUM_FRAMES))) begin
            state_d = StActive;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
          end else begin
            state_d    = StDone;
            busy_d     = 1'b0;
            all_done_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CAMERA_CLK) begin
    if (rst) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      blank_q      <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      all_done_q   <= 1'b0;
      busy_q       <= 1'b0;
      rd_q         <= 1'b0;
      rd_mk_q      <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      blank_q      <= blank_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      all_done_q   <= all_done_d;
      busy_q       <= busy_d;
      rd_q         <= rd_d;
      rd_mk_q      <= rd_mk_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      cnt_q        <= cnt_d;
    end
  end

  // Outputs; payload forced to zero when nothing is valid.
  always_comb begin
    mem_en      = issue;
    mem_addr    = addr_q;
    m_if.m_valid = valid;
    m_if.m_data  = valid ? head.data : '0;
    m_if.m_sof   = valid & head.sof;
    m_if.m_eol   = valid & head.eol;
    m_if.m_eof   = valid & head.eof;
    frame_done  = frame_done_q;
    all_done    = all_done_q;
    busy        = busy_q;
    frame_cnt   = frame_cnt_q;
  end

endmodule
